// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// The frame-state encoding and the prescale-to-bit-period shift live here so
// that both directions agree on them.
package uart_pkg;

  // Frame states, in the order a frame is sent
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Bit period in clocks is prescale << PRESCALE_SHIFT (prescale * 8)
  localparam int PRESCALE_SHIFT = 3;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
// It counts down from B-1 to 0, where B = prescale * 8, and raises bit_tick
// during the last clock of every bit. The counter reloads on load (the start
// of a frame) and again on every tick, so each bit lasts exactly B clocks.
// A prescale of 0 is treated as 1.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] prescale,
  output logic        bit_tick
);

  localparam int CNT_W = 16 + PRESCALE_SHIFT;

  logic [15:0]      prescale_eff;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] cnt;

  // Reload value B-1, with prescale 0 promoted to 1
  always_comb begin
    prescale_eff = (prescale == 16'd0) ? 16'd1 : prescale;
    reload       = {prescale_eff, {PRESCALE_SHIFT{1'b0}}} - CNT_W'(1);
  end

  assign bit_tick = (cnt == '0) && !load;

  // Down-counter, reloaded at frame start and at every bit boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load || bit_tick) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with an AXI-Stream style byte input.
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
// one stop bit (1). Each bit lasts prescale*8 clocks; data and prescale are
// latched at the handshake and hold for the whole frame.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// the data and the stop bit (even parity, or odd when PARITY_ODD = 1).
// Reset rst is asynchronous and active-low; it aborts any frame in progress.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_t           state;
  uart_state_t           state_next;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      bit_idx_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic [15:0]           prescale_q;
  logic [15:0]           baud_prescale;
  logic                  transfer;
  logic                  bit_tick;
  logic                  txd_next;

  assign transfer = s_axis_tvalid && s_axis_tready;

  // The first bit of a frame is timed from the incoming prescale; all later
  // reloads use the latched copy so mid-frame changes have no effect.
  assign baud_prescale = transfer ? prescale : prescale_q;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);
`else
  localparam bit unused_parity_odd = (PARITY_ODD != 0);
`endif

  uart_baud_gen u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (transfer),
    .prescale (baud_prescale),
    .bit_tick (bit_tick)
  );

  // Next-state, bit index and next serial bit
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    txd_next     = 1'b1;
    case (state)
      IDLE: begin
        if (transfer) state_next = START;
      end
      START: begin
        if (bit_tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = data_q[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = parity_bit;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  // State and registered outputs; tready stays low until the first edge
  // after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bit_idx       <= '0;
      txd           <= 1'b1;
      busy          <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_next;
      bit_idx       <= bit_idx_next;
      txd           <= txd_next;
      busy          <= (state_next != IDLE);
      s_axis_tready <= (state_next == IDLE);
    end
  end

  // Latch the byte and its bit period at the handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q     <= '0;
      prescale_q <= '0;
    end else if (transfer) begin
      data_q     <= s_axis_tdata;
      prescale_q <= prescale;
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_tdata  input  DATA_WIDTH  byte to transmit.
REQ-006 SHALL have port s_axis_tvalid  input  1  tdata valid.
REQ-007 SHALL have port s_axis_tready  output  1  block can accept a byte.
REQ-008 SHALL have port txd  output  1  serial line; idle high.
REQ-009 SHALL have port busy  output  1  a frame is in progress.
REQ-010 SHALL have port prescale  input  16  clocks per bit divided by 8 (bit period B = prescale*8 clocks).

Function
REQ-011 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL drive s_axis_tready = 1 only in IDLE; transfer occurs on a rising edge with tvalid && tready.
REQ-013 SHALL, on transfer at edge T, latch tdata and prescale, enter START, and drive txd = 0 and busy = 1 from T+1.
REQ-014 SHALL hold each bit for exactly B clocks using a bit-period counter reloaded at every bit boundary.
REQ-015 SHALL send data LSB first in DATA, with a bit index counter from 0 to DATA_WIDTH-1.
REQ-016 SHALL drive txd = 1 for B clocks in STOP, then return to IDLE with tready = 1 and busy = 0 on the next cycle.
REQ-017 SHALL make frame length N*B clocks (N = DATA_WIDTH+2, or DATA_WIDTH+3 with parity); back-to-back start edges are N*B+1 clocks apart.
REQ-018 SHALL ignore prescale changes and tdata/tvalid changes mid-frame; the latched values govern the whole frame.
REQ-019 SHALL treat a latched prescale of 0 as 1 (B = 8).
REQ-020 SHALL keep txd = 1 in IDLE regardless of tvalid.
REQ-021 SHALL leave tdata unconsumed while tready = 0; the upstream holds it per AXI-Stream rules.

Reset
REQ-022 SHALL on rst = 0 immediately force state IDLE, txd = 1, busy = 0, s_axis_tready = 0, and all counters and the data register to 0.
REQ-023 SHALL assert s_axis_tready on the first clock edge after rst deasserts.
REQ-024 SHALL, on reset mid-frame, abort the frame with txd = 1 immediately; a truncated frame on the line is acceptable.

Configuration
REQ-025 SHALL use macro UART_TX_PARITY_EN.
REQ-026 SHALL, with UART_TX_PARITY_EN defined, pass through PARITY for B clocks between DATA and STOP.
REQ-027 SHALL compute the parity bit as XOR of the latched data, inverted when PARITY_ODD = 1.
REQ-028 SHALL, without UART_TX_PARITY_EN, go DATA -> STOP directly and generate no parity logic.

Structure
REQ-029 SHALL take the state enum (IDLE, START, DATA, PARITY, STOP) and constant PRESCALE_SHIFT = 3 from shared package uart_pkg, also used by the receiver.
REQ-030 SHALL place the bit-period counter in sub-module uart_baud_gen (load, prescale in, bit_tick out).

Verification
REQ-031 SHALL cover: prescale=1, tdata=0x55, no parity -> txd 0,1,0,1,0,1,0,1,0,1 each bit 8 clocks; busy high 80 clocks; tready high again at clock 81.
REQ-032 SHALL cover: two bytes 0xA3, 0x0F with tvalid held high, prescale=2 -> start edges 161 clocks apart; decoded bytes equal the input.
REQ-033 SHALL cover: UART_TX_PARITY_EN with PARITY_ODD=0, tdata=0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 11*B clocks.
REQ-034 SHALL cover: prescale changed from 4 to 1 mid-frame -> all bits stay 32 clocks.
REQ-035 SHALL cover: rst asserted during data bit 3 -> txd = 1 and busy = 0 at once; after release, tready = 1 on the first edge and a fresh 0x3C frame transmits correctly.
REQ-036 SHALL cover: prescale=0, tdata=0xFF -> bit period is 8 clocks.
